// File: rtl/nand_op_event_gen_if.sv
// Command hand-off and status-result bundle observed by the NAND operation
// event generator. The master side is the channel controller or PHY, which
// drives everything. The slave side is the event generator, which only watches.
interface nand_op_event_gen_if #(
  parameter int WAY_WD = 2
);
  logic              i_cmd_valid;
  logic              i_cmd_ready;
  logic [1:0]        i_cmd_op;
  logic [WAY_WD-1:0] i_cmd_way;
  logic              i_status_valid;
  logic [WAY_WD-1:0] i_status_way;
  logic              i_status_fail;

  modport master (
    output i_cmd_valid, i_cmd_ready, i_cmd_op, i_cmd_way,
    output i_status_valid, i_status_way, i_status_fail
  );

  modport slave (
    input i_cmd_valid, i_cmd_ready, i_cmd_op, i_cmd_way,
    input i_status_valid, i_status_way, i_status_fail
  );
endinterface

// File: rtl/nand_op_event_gen.sv
// Per-way NAND operation event generator. It tracks each way through
// IDLE -> ARMED -> BUSY -> IDLE from command accepts and synchronized R/B#.
// It emits registered single-cycle start, end and fail pulses for the
// performance monitor.
module nand_op_event_gen #(
  parameter int WAY     = 4,
  parameter int WAY_WD  = 2,
  parameter int ARM_TMO = 255
) (
  input  logic                i_bus_clk,
  input  logic                i_bus_rstn,
  nand_op_event_gen_if.slave  cmd_if,
  input  logic [WAY-1:0]      i_rb_n,
  output logic [WAY-1:0]      o_prog_start,
  output logic [WAY-1:0]      o_prog_end,
  output logic [WAY-1:0]      o_read_start,
  output logic [WAY-1:0]      o_read_end,
  output logic [WAY-1:0]      o_erase_start,
  output logic [WAY-1:0]      o_erase_end,
  output logic [WAY-1:0]      o_op_fail,
  output logic [WAY-1:0]      o_way_busy,
  output logic                o_cmd_drop
);

  localparam int              CNT_W   = $clog2(ARM_TMO + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ARM_TMO);

  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BUSY  = 2'd2
  } state_e;

  state_e           state_q [WAY];
  state_e           state_d [WAY];
  logic [1:0]       op_q    [WAY];
  logic [1:0]       op_d    [WAY];
  logic [CNT_W-1:0] cnt_q   [WAY];
  logic [CNT_W-1:0] cnt_d   [WAY];

  logic [WAY-1:0] rb_meta_q, rb_s_q;
  logic [WAY-1:0] prog_start_d, prog_end_d, read_start_d, read_end_d;
  logic [WAY-1:0] erase_start_d, erase_end_d, op_fail_d, way_busy_d;
  logic           cmd_drop_d;
  logic           acc;

  assign acc = cmd_if.i_cmd_valid & cmd_if.i_cmd_ready & (cmd_if.i_cmd_op != 2'b00);

  // Two-flop synchronizer for the asynchronous R/B# pins; idles high (ready)
  always_ff @(posedge i_bus_clk or negedge i_bus_rstn) begin
    if (!i_bus_rstn) begin
      rb_meta_q <= '1;
      rb_s_q    <= '1;
    end else begin
      rb_meta_q <= i_rb_n;
      rb_s_q    <= rb_meta_q;
    end
  end

  // Per-way next state plus the pulses that the transitions produce
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    prog_start_d  = '0;
    prog_end_d    = '0;
    read_start_d  = '0;
    read_end_d    = '0;
    erase_start_d = '0;
    erase_end_d   = '0;
    op_fail_d     = '0;
    way_busy_d    = '0;
    cmd_drop_d    = acc && (state_q[cmd_if.i_cmd_way] != IDLE);

    for (int w = 0; w < WAY; w++) begin
      case (state_q[w])
        IDLE: begin
          if (acc && (cmd_if.i_cmd_way == WAY_WD'(w))) begin
            state_d[w] = ARMED;
            op_d[w]    = cmd_if.i_cmd_op;
            cnt_d[w]   = '0;
            prog_start_d[w]  = (cmd_if.i_cmd_op == OP_PROG);
            read_start_d[w]  = (cmd_if.i_cmd_op == OP_READ);
            erase_start_d[w] = (cmd_if.i_cmd_op == OP_ERASE);
          end
        end
        ARMED: begin
          if (!rb_s_q[w]) begin
            state_d[w] = BUSY;
            cnt_d[w]   = '0;
          end else if (cnt_q[w] == CNT_MAX) begin
            // The device never went busy, so close the operation as failed.
            state_d[w]     = IDLE;
            cnt_d[w]       = '0;
            op_fail_d[w]   = 1'b1;
            prog_end_d[w]  = (op_q[w] == OP_PROG);
            read_end_d[w]  = (op_q[w] == OP_READ);
            erase_end_d[w] = (op_q[w] == OP_ERASE);
          end else begin
            cnt_d[w] = cnt_q[w] + 1'b1;
          end
        end
        BUSY: begin
          if (rb_s_q[w]) begin
            state_d[w]     = IDLE;
            prog_end_d[w]  = (op_q[w] == OP_PROG);
            read_end_d[w]  = (op_q[w] == OP_READ);
            erase_end_d[w] = (op_q[w] == OP_ERASE);
          end
        end
        default: state_d[w] = IDLE;
      endcase
      way_busy_d[w] = (state_d[w] != IDLE);
    end

    // A status FAIL merges with a timeout fail on the same way into one pulse.
    if (cmd_if.i_status_valid && cmd_if.i_status_fail)
      op_fail_d[cmd_if.i_status_way] = 1'b1;
  end

  // State, op latches, arm counters and all registered outputs
  always_ff @(posedge i_bus_clk or negedge i_bus_rstn) begin
    if (!i_bus_rstn) begin
      state_q       <= '{default: IDLE};
      op_q          <= '{default: 2'b00};
      cnt_q         <= '{default: '0};
      o_prog_start  <= '0;
      o_prog_end    <= '0;
      o_read_start  <= '0;
      o_read_end    <= '0;
      o_erase_start <= '0;
      o_erase_end   <= '0;
      o_op_fail     <= '0;
      o_way_busy    <= '0;
      o_cmd_drop    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      o_prog_start  <= prog_start_d;
      o_prog_end    <= prog_end_d;
      o_read_start  <= read_start_d;
      o_read_end    <= read_end_d;
      o_erase_start <= erase_start_d;
      o_erase_end   <= erase_end_d;
      o_op_fail     <= op_fail_d;
      o_way_busy    <= way_busy_d;
      o_cmd_drop    <= cmd_drop_d;
    end
  end

endmodule

// File: tb/tb_nand_op_event_gen.sv
// Directed bench for nand_op_event_gen with WAY=4 and ARM_TMO=8.
// Every output is packed into one vector and compared against hand-computed
// values. The vectors are checked one cycle at a time, #1 after each rising edge.
module tb_nand_op_event_gen;

  logic       clk;
  logic       rstn;
  logic [3:0] rb_n;
  logic [3:0] prog_s, prog_e, read_s, read_e, erase_s, erase_e, op_fail, way_busy;
  logic       cmd_drop;

  int n_cmp;
  int n_fail;

  nand_op_event_gen_if #(.WAY_WD(2)) bus ();

  nand_op_event_gen #(.WAY(4), .WAY_WD(2), .ARM_TMO(8)) dut (
    .i_bus_clk     (clk),
    .i_bus_rstn    (rstn),
    .cmd_if        (bus),
    .i_rb_n        (rb_n),
    .o_prog_start  (prog_s),
    .o_prog_end    (prog_e),
    .o_read_start  (read_s),
    .o_read_end    (read_e),
    .o_erase_start (erase_s),
    .o_erase_end   (erase_e),
    .o_op_fail     (op_fail),
    .o_way_busy    (way_busy),
    .o_cmd_drop    (cmd_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        r;
    logic [1:0]  op;
    logic [1:0]  way;
    logic [3:0]  rb;
    logic        sv;
    logic [1:0]  sw;
    logic        sf;
    logic [32:0] exp;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [32:0] mk(input logic [3:0] ps, input logic [3:0] pe,
                                     input logic [3:0] rs, input logic [3:0] re,
                                     input logic [3:0] es, input logic [3:0] ee,
                                     input logic [3:0] f,  input logic [3:0] b,
                                     input logic d);
    return {ps, pe, rs, re, es, ee, f, b, d};
  endfunction

  function automatic vec_t mkv(input logic v, input logic r, input logic [1:0] op,
                               input logic [1:0] way, input logic [3:0] rb,
                               input logic [32:0] exp);
    vec_t t;
    t.v = v; t.r = r; t.op = op; t.way = way; t.rb = rb;
    t.sv = 1'b0; t.sw = 2'd0; t.sf = 1'b0; t.exp = exp;
    return t;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [32:0] exp);
    logic [32:0] obs;
    obs = {prog_s, prog_e, read_s, read_e, erase_s, erase_e, op_fail, way_busy, cmd_drop};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got ps=%b pe=%b rs=%b re=%b es=%b ee=%b fail=%b busy=%b drop=%b, want %h (got %h)",
               name, obs[32:29], obs[28:25], obs[24:21], obs[20:17], obs[16:13],
               obs[12:9], obs[8:5], obs[4:1], obs[0], exp, obs);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] way);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_ready = 1'b1;
    bus.i_cmd_op    = op;
    bus.i_cmd_way   = way;
  endtask

  task automatic idle();
    bus.i_cmd_valid    = 1'b0;
    bus.i_cmd_ready    = 1'b0;
    bus.i_cmd_op       = 2'b00;
    bus.i_cmd_way      = 2'd0;
    bus.i_status_valid = 1'b0;
    bus.i_status_way   = 2'd0;
    bus.i_status_fail  = 1'b0;
  endtask

  localparam logic [32:0] Z = 33'd0;

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // Program way 2 with a short busy window, a drop, op 00 and valid without ready.
    tbl[0]  = mkv(0, 0, 2'b00, 2'd0, 4'b1111, Z);
    tbl[1]  = mkv(1, 1, 2'b00, 2'd0, 4'b1111, Z);
    tbl[2]  = mkv(1, 0, 2'b01, 2'd2, 4'b1111, Z);
    tbl[3]  = mkv(1, 1, 2'b01, 2'd2, 4'b1111, mk(4'b0100, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tbl[4]  = mkv(0, 0, 2'b00, 2'd0, 4'b1111, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tbl[5]  = mkv(0, 0, 2'b00, 2'd0, 4'b1111, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tbl[6]  = mkv(0, 0, 2'b00, 2'd0, 4'b1011, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tbl[7]  = mkv(0, 0, 2'b00, 2'd0, 4'b1011, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tbl[8]  = mkv(0, 0, 2'b00, 2'd0, 4'b1011, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tbl[9]  = mkv(1, 1, 2'b10, 2'd2, 4'b1011, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 1));
    tbl[10] = mkv(0, 0, 2'b00, 2'd0, 4'b1011, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tbl[11] = mkv(0, 0, 2'b00, 2'd0, 4'b1111, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tbl[12] = mkv(0, 0, 2'b00, 2'd0, 4'b1111, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tbl[13] = mkv(0, 0, 2'b00, 2'd0, 4'b1111, mk(0, 4'b0100, 0, 0, 0, 0, 0, 0, 0));
    tbl[14] = mkv(0, 0, 2'b00, 2'd0, 4'b1111, Z);

    idle();
    rb_n = 4'b1111;
    rstn = 1'b0;
    repeat (3) cyc();
    chk("reset_hold", Z);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      bus.i_cmd_valid    = tbl[i].v;
      bus.i_cmd_ready    = tbl[i].r;
      bus.i_cmd_op       = tbl[i].op;
      bus.i_cmd_way      = tbl[i].way;
      bus.i_status_valid = tbl[i].sv;
      bus.i_status_way   = tbl[i].sw;
      bus.i_status_fail  = tbl[i].sf;
      rb_n               = tbl[i].rb;
      cyc();
      chk($sformatf("tbl[%0d]", i), tbl[i].exp);
    end
    idle();

    // Program way 2, R/B# low for 40 cycles.
    cmd(2'b01, 2'd2);
    cyc(); chk("t1_start", mk(4'b0100, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    idle();
    cyc(); chk("t1_arm1", mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    cyc(); chk("t1_arm2", mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    rb_n = 4'b1011;
    for (int i = 0; i < 40; i++) begin
      cyc(); chk("t1_busy", mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    end
    rb_n = 4'b1111;
    cyc(); chk("t1_rise1", mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    cyc(); chk("t1_rise2", mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    cyc(); chk("t1_end", mk(0, 4'b0100, 0, 0, 0, 0, 0, 0, 0));
    cyc(); chk("t1_after", Z);

    // Erase way 1 with R/B# held high: timeout after ARM_TMO.
    cmd(2'b11, 2'd1);
    cyc(); chk("t3_start", mk(0, 0, 0, 0, 4'b0010, 0, 0, 4'b0010, 0));
    idle();
    for (int i = 0; i < 8; i++) begin
      cyc(); chk("t3_armed", mk(0, 0, 0, 0, 0, 0, 0, 4'b0010, 0));
    end
    cyc(); chk("t3_timeout", mk(0, 0, 0, 0, 0, 4'b0010, 4'b0010, 0, 0));
    cyc(); chk("t3_after", Z);

    // Read way 0 and program way 3 end together, plus a drop on busy way 0.
    rb_n = 4'b0110;
    cmd(2'b10, 2'd0);
    cyc(); chk("t4_rd_start", mk(0, 0, 4'b0001, 0, 0, 0, 0, 4'b0001, 0));
    cmd(2'b01, 2'd3);
    cyc(); chk("t4_pg_start", mk(4'b1000, 0, 0, 0, 0, 0, 0, 4'b1001, 0));
    idle();
    cyc(); chk("t4_busy1", mk(0, 0, 0, 0, 0, 0, 0, 4'b1001, 0));
    cyc(); chk("t4_busy2", mk(0, 0, 0, 0, 0, 0, 0, 4'b1001, 0));
    cmd(2'b10, 2'd0);
    cyc(); chk("t2_drop", mk(0, 0, 0, 0, 0, 0, 0, 4'b1001, 1));
    idle();
    cyc(); chk("t2_drop_once", mk(0, 0, 0, 0, 0, 0, 0, 4'b1001, 0));
    rb_n = 4'b1111;
    cyc(); chk("t4_rise1", mk(0, 0, 0, 0, 0, 0, 0, 4'b1001, 0));
    cyc(); chk("t4_rise2", mk(0, 0, 0, 0, 0, 0, 0, 4'b1001, 0));
    cyc(); chk("t4_both_end", mk(0, 4'b1000, 0, 4'b0001, 0, 0, 0, 0, 0));
    cyc(); chk("t4_after", Z);

    // Status fail on way 3 in the same cycle as its timeout.
    cmd(2'b01, 2'd3);
    cyc(); chk("t5_start", mk(4'b1000, 0, 0, 0, 0, 0, 0, 4'b1000, 0));
    idle();
    for (int i = 0; i < 8; i++) begin
      cyc(); chk("t5_armed", mk(0, 0, 0, 0, 0, 0, 0, 4'b1000, 0));
    end
    bus.i_status_valid = 1'b1;
    bus.i_status_way   = 2'd3;
    bus.i_status_fail  = 1'b1;
    cyc(); chk("t5_merged_fail", mk(0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0, 0));
    idle();
    cyc(); chk("t5_single_pulse", Z);
    bus.i_status_valid = 1'b1;
    bus.i_status_way   = 2'd1;
    bus.i_status_fail  = 1'b1;
    cyc(); chk("t5_status_idle_way", mk(0, 0, 0, 0, 0, 0, 4'b0010, 0, 0));
    bus.i_status_way   = 2'd2;
    bus.i_status_fail  = 1'b0;
    cyc(); chk("t5_status_pass", Z);
    idle();

    // Reset while ways 1 and 2 are busy.
    rb_n = 4'b1001;
    cmd(2'b01, 2'd1);
    cyc(); chk("t6_pg_start", mk(4'b0010, 0, 0, 0, 0, 0, 0, 4'b0010, 0));
    cmd(2'b11, 2'd2);
    cyc(); chk("t6_er_start", mk(0, 0, 0, 0, 4'b0100, 0, 0, 4'b0110, 0));
    idle();
    cyc(); chk("t6_busy1", mk(0, 0, 0, 0, 0, 0, 0, 4'b0110, 0));
    cyc(); chk("t6_busy2", mk(0, 0, 0, 0, 0, 0, 0, 4'b0110, 0));
    rstn = 1'b0;
    #1; chk("t6_async_reset", Z);
    rb_n = 4'b1111;
    cyc(); cyc(); chk("t6_in_reset", Z);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("t6_no_end", Z);
    end
    cmd(2'b10, 2'd2);
    cyc(); chk("t6_restart", mk(0, 0, 4'b0100, 0, 0, 0, 0, 4'b0100, 0));
    idle();
    cyc(); chk("t6_restart_armed", mk(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
